alu_vector_checker: RTL and testbench

//  Self-running stimulus and response checker for the 5-bit combinational ALU (S/X/Y in, F/Overflow/Cout out).

---
 rtl/alu_vector_checker.sv | 173 +++++++++++++++++
 tb/tb_alu_vector_checker.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_vector_checker.sv
// Self-running stimulus/response checker for a 5-bit combinational ALU.
// Steps through a fixed vector table and drives op select and operands to the ALU.
// After a programmable settle time it compares F/Ovf/Cout with a built-in golden model.
// Pass and fail counts, plus the index of the first failure, are kept for the last run.
module alu_vector_checker #(
  parameter int unsigned SETTLE_CYC = 2,  // 1..15
  parameter int unsigned NUM_VEC    = 8   // 1..8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  output logic [1:0] alu_s_o,
  output logic [4:0] alu_x_o,
  output logic [4:0] alu_y_o,
  input  logic [4:0] alu_f_i,
  input  logic       alu_ovf_i,
  input  logic       alu_cout_i,
  output logic       busy_o,
  output logic       done_o,
  output logic [3:0] pass_cnt_o,
  output logic [3:0] fail_cnt_o,
  output logic [2:0] first_fail_o
);

  localparam logic [3:0] SettleLoad = 4'(SETTLE_CYC - 1);
  localparam logic [2:0] LastIdx    = 3'(NUM_VEC - 1);

  typedef enum logic [2:0] {StIdle, StDrive, StSettle, StCheck, StDone} state_e;

  state_e     state_q;
  logic [2:0] idx_q;
  logic [3:0] settle_q;
  logic [1:0] alu_s_q;
  logic [4:0] alu_x_q;
  logic [4:0] alu_y_q;
  logic       busy_q;
  logic       done_q;
  logic [3:0] pass_cnt_q;
  logic [3:0] fail_cnt_q;
  logic [2:0] first_fail_q;

  logic [11:0] tab_entry;
  logic [6:0]  exp_res;
  logic        vec_match;

  // Stimulus table, packed as {S, X, Y}.
  function automatic logic [11:0] vec_entry(input logic [2:0] i);
    logic [11:0] e;
    case (i)
      3'd0:    e = {2'b00, 5'b00111, 5'b00111};
      3'd1:    e = {2'b01, 5'b00011, 5'b00001};
      3'd2:    e = {2'b00, 5'b01111, 5'b00111};
      3'd3:    e = {2'b01, 5'b00011, 5'b01001};
      3'd4:    e = {2'b10, 5'b01111, 5'b01111};
      3'd5:    e = {2'b11, 5'b00111, 5'b00001};
      3'd6:    e = {2'b10, 5'b01001, 5'b00001};
      default: e = {2'b11, 5'b00011, 5'b10001};
    endcase
    return e;
  endfunction

  // Reference ALU, result packed as {F, Ovf, Cout}.
  function automatic logic [6:0] golden(input logic [1:0] s, input logic [4:0] x,
                                        input logic [4:0] y);
    logic [5:0] sum;
    logic [4:0] f;
    logic       ovf;
    logic       c;
    sum = '0;
    f   = '0;
    ovf = 1'b0;
    c   = 1'b0;
    case (s)
      2'b00: begin
        sum = {1'b0, x} + {1'b0, y};
        f   = sum[4:0];
        c   = sum[5];
        ovf = (x[4] == y[4]) && (f[4] != x[4]);
      end
      2'b01: begin
        // Cout=1 means no borrow.
        sum = {1'b0, x} + {1'b0, ~y} + 6'd1;
        f   = sum[4:0];
        c   = sum[5];
        ovf = (x[4] != y[4]) && (f[4] != x[4]);
      end
      2'b10:   f = x & y;
      default: f = x | y;
    endcase
    return {f, ovf, c};
  endfunction

  // Expected ALU response for the vector currently selected by idx.
  always_comb begin
    tab_entry = vec_entry(idx_q);
    exp_res   = golden(tab_entry[11:10], tab_entry[9:5], tab_entry[4:0]);
    vec_match = ({alu_f_i, alu_ovf_i, alu_cout_i} == exp_res);
  end

  // Sequencer FSM with registered outputs; start is only honoured in IDLE or DONE.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      settle_q     <= '0;
      alu_s_q      <= '0;
      alu_x_q      <= '0;
      alu_y_q      <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_cnt_q   <= '0;
      fail_cnt_q   <= '0;
      first_fail_q <= '0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (start_i) begin
            state_q      <= StDrive;
            idx_q        <= '0;
            pass_cnt_q   <= '0;
            fail_cnt_q   <= '0;
            first_fail_q <= '0;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
          end
        end
        StDrive: begin
          alu_s_q  <= tab_entry[11:10];
          alu_x_q  <= tab_entry[9:5];
          alu_y_q  <= tab_entry[4:0];
          settle_q <= SettleLoad;
          state_q  <= StSettle;
        end
        StSettle: begin
          if (settle_q == 4'd0) begin
            state_q <= StCheck;
          end else begin
            settle_q <= settle_q - 4'd1;
          end
        end
        StCheck: begin
          if (vec_match) begin
            pass_cnt_q <= pass_cnt_q + 4'd1;
          end else begin
            fail_cnt_q <= fail_cnt_q + 4'd1;
            if (fail_cnt_q == 4'd0) begin
              first_fail_q <= idx_q;
            end
          end
          if (idx_q == LastIdx) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            idx_q   <= idx_q + 3'd1;
            state_q <= StDrive;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign alu_s_o      = alu_s_q;
  assign alu_x_o      = alu_x_q;
  assign alu_y_o      = alu_y_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign pass_cnt_o   = pass_cnt_q;
  assign fail_cnt_o   = fail_cnt_q;
  assign first_fail_o = first_fail_q;

endmodule

// File: tb/tb_alu_vector_checker.sv
// Bench for alu_vector_checker: a behavioural ALU (correct or with a chosen fault) is attached,
// expected run totals are queued at each start and compared when done rises.
module tb_alu_vector_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance A: default parameters, ALU with selectable fault.
  logic       start_a = 1'b0;
  logic [1:0] s_a;
  logic [4:0] x_a, y_a, f_a;
  logic       ovf_a, cout_a, busy_a, done_a;
  logic [3:0] pass_a, fail_a;
  logic [2:0] first_a;

  // Instance B: NUM_VEC=3, SETTLE_CYC=1, correct ALU.
  logic       start_b = 1'b0;
  logic [1:0] s_b;
  logic [4:0] x_b, y_b, f_b;
  logic       ovf_b, cout_b, busy_b, done_b;
  logic [3:0] pass_b, fail_b;
  logic [2:0] first_b;

  int alu_mode = 0;  // 0 correct, 1 Ovf stuck at 0, 2 SUB computes Y-X

  alu_vector_checker #(.SETTLE_CYC(2), .NUM_VEC(8)) dut_a (
    .clk_i(clk), .rst_i(rst), .start_i(start_a),
    .alu_s_o(s_a), .alu_x_o(x_a), .alu_y_o(y_a),
    .alu_f_i(f_a), .alu_ovf_i(ovf_a), .alu_cout_i(cout_a),
    .busy_o(busy_a), .done_o(done_a),
    .pass_cnt_o(pass_a), .fail_cnt_o(fail_a), .first_fail_o(first_a)
  );

  alu_vector_checker #(.SETTLE_CYC(1), .NUM_VEC(3)) dut_b (
    .clk_i(clk), .rst_i(rst), .start_i(start_b),
    .alu_s_o(s_b), .alu_x_o(x_b), .alu_y_o(y_b),
    .alu_f_i(f_b), .alu_ovf_i(ovf_b), .alu_cout_i(cout_b),
    .busy_o(busy_b), .done_o(done_b),
    .pass_cnt_o(pass_b), .fail_cnt_o(fail_b), .first_fail_o(first_b)
  );

  // Vector table with the documented expected results {F, Ovf, Cout}.
  logic [1:0] tv_s   [8] = '{2'b00, 2'b01, 2'b00, 2'b01, 2'b10, 2'b11, 2'b10, 2'b11};
  logic [4:0] tv_x   [8] = '{5'b00111, 5'b00011, 5'b01111, 5'b00011,
                             5'b01111, 5'b00111, 5'b01001, 5'b00011};
  logic [4:0] tv_y   [8] = '{5'b00111, 5'b00001, 5'b00111, 5'b01001,
                             5'b01111, 5'b00001, 5'b00001, 5'b10001};
  logic [6:0] tv_exp [8] = '{{5'b01110, 2'b00}, {5'b00010, 2'b01}, {5'b10110, 2'b10},
                             {5'b11010, 2'b00}, {5'b01111, 2'b00}, {5'b00111, 2'b00},
                             {5'b00001, 2'b00}, {5'b10011, 2'b00}};

  // Stand-in ALU, optionally faulty; result {F, Ovf, Cout}.
  function automatic logic [6:0] alu_model(input int mode, input logic [1:0] s,
                                           input logic [4:0] x, input logic [4:0] y);
    logic [5:0] r;
    logic [4:0] a, b;
    logic       v;
    r = '0;
    v = 1'b0;
    case (s)
      2'b00: begin
        r = {1'b0, x} + {1'b0, y};
        v = (x[4] == y[4]) && (r[4] != x[4]);
      end
      2'b01: begin
        a = (mode == 2) ? y : x;
        b = (mode == 2) ? x : y;
        r = {1'b0, a} + {1'b0, ~b} + 6'd1;
        v = (a[4] != b[4]) && (r[4] != a[4]);
      end
      2'b10:   r = {1'b0, x & y};
      default: r = {1'b0, x | y};
    endcase
    if (mode == 1) v = 1'b0;
    return {r[4:0], v, (s[1] ? 1'b0 : r[5])};
  endfunction

  always_comb {f_a, ovf_a, cout_a} = alu_model(alu_mode, s_a, x_a, y_a);
  always_comb {f_b, ovf_b, cout_b} = alu_model(0, s_b, x_b, y_b);

  typedef struct packed {
    logic [3:0] pass;
    logic [3:0] fail;
    logic [2:0] first;
    int         lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cur     = 0;  // 0 observes dut_a, 1 observes dut_b

  logic [1:0] o_s;
  logic [4:0] o_x, o_y;
  logic       o_busy, o_done;
  logic [3:0] o_pass, o_fail;
  logic [2:0] o_first;
  always_comb begin
    o_s     = (cur == 0) ? s_a     : s_b;
    o_x     = (cur == 0) ? x_a     : x_b;
    o_y     = (cur == 0) ? y_a     : y_b;
    o_busy  = (cur == 0) ? busy_a  : busy_b;
    o_done  = (cur == 0) ? done_a  : done_b;
    o_pass  = (cur == 0) ? pass_a  : pass_b;
    o_fail  = (cur == 0) ? fail_a  : fail_b;
    o_first = (cur == 0) ? first_a : first_b;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_start(input logic v);
    if (cur == 0) start_a = v;
    else          start_b = v;
  endtask

  // Independent prediction of a run's totals from the table and the attached ALU.
  function automatic exp_t predict(input int mode, input int nvec, input int per);
    exp_t e;
    e = '0;
    for (int i = 0; i < nvec; i++) begin
      if (alu_model(mode, tv_s[i], tv_x[i], tv_y[i]) == tv_exp[i]) begin
        e.pass = e.pass + 4'd1;
      end else begin
        if (e.fail == 4'd0) e.first = 3'(i);
        e.fail = e.fail + 4'd1;
      end
    end
    e.lat = nvec * per;
    return e;
  endfunction

  // One run: start pulse, per-cycle operand checks, optional extra start or reset mid-run.
  task automatic run(input int mode, input int nvec, input int per, input int inject_at,
                     input int rst_at);
    exp_t e;
    int   n;
    int   k;
    bit   seen;
    alu_mode = mode;
    sb_q.push_back(predict(mode, nvec, per));
    set_start(1'b1);
    cyc();
    set_start(1'b0);
    n    = 0;
    seen = 1'b0;
    while (n < nvec * per + 8 && !seen) begin
      cyc();
      n++;
      set_start(n == inject_at);
      if (n == 1) begin
        check_val("start_state", {o_busy, o_done, o_pass, o_fail}, {1'b1, 1'b0, 8'h00});
      end
      k = (n - 1) / per;
      if (k > nvec - 1) k = nvec - 1;
      check_val($sformatf("operands_n%0d", n), {o_s, o_x, o_y}, {tv_s[k], tv_x[k], tv_y[k]});
      if (n == rst_at) begin
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check_val("rst_midrun", {o_busy, o_done, o_pass, o_fail, o_first, o_s, o_x, o_y}, '0);
        cyc();
        check_val("rst_idle", {o_busy, o_done, o_s, o_x, o_y}, '0);
        void'(sb_q.pop_front());
        return;
      end
      seen = o_done;
    end
    set_start(1'b0);
    if (!seen) check_val("done_timeout", 32'd0, 32'd1);
    e = sb_q.pop_front();
    check_val("latency", n, e.lat);
    check_val("pass_cnt", o_pass, e.pass);
    check_val("fail_cnt", o_fail, e.fail);
    if (e.fail != 4'd0) check_val("first_fail", o_first, e.first);
    check_val("done_flags", {o_busy, o_done}, 2'b01);
    cyc();
    check_val("done_hold", {o_done, o_s, o_x, o_y},
              {1'b1, tv_s[nvec-1], tv_x[nvec-1], tv_y[nvec-1]});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    cur = 0;
    check_val("reset_a", {busy_a, done_a, pass_a, fail_a, first_a, s_a, x_a, y_a}, '0);
    check_val("reset_b", {busy_b, done_b, pass_b, fail_b, first_b, s_b, x_b, y_b}, '0);
    cyc();

    run(0, 8, 4, 0, 0);   // correct ALU
    run(1, 8, 4, 0, 0);   // Ovf stuck at 0
    run(2, 8, 4, 0, 0);   // SUB reversed
    run(1, 8, 4, 17, 0);  // start during SETTLE of vector 4 is ignored
    run(0, 8, 4, 0, 0);   // restart from DONE clears the earlier failure
    run(0, 8, 4, 0, 23);  // reset during CHECK of vector 5
    run(0, 8, 4, 0, 0);   // IDLE after reset accepts a new run

    cur = 1;
    run(0, 3, 3, 0, 0);   // NUM_VEC=3, SETTLE_CYC=1

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
